// File: rtl/dec_issue_ctrl_pkg.sv
// Shared decode->execute pipeline types: FSM states, widths
// and the all-zero bubble bundle used when the latch is flushed.
package dec_issue_ctrl_pkg;

   localparam int REGA_W_DEF = 6;
   localparam int REGB_W_DEF = 5;
   localparam int LAM_CTRL_W = 9;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MEM_WAIT,
      ST_LOAD_USE,
      ST_FLUSH
   } state_e;

   typedef struct packed {
      logic [REGA_W_DEF-1:0] sel_a;
      logic [REGB_W_DEF-1:0] sel_b;
      logic [REGA_W_DEF-1:0] sel_out;
      logic                  lam_new;
      logic [LAM_CTRL_W-1:0] lam_control;
      logic                  new_jmp;
   } dec_bundle_t;

   localparam dec_bundle_t BUBBLE = '0;

endpackage

// File: rtl/dec_issue_ctrl_hazard_cmp.sv
// Load-use compare of the next instruction's sources against the
// pending load destination; register 0 never creates a hazard.
module hazard_cmp
   import dec_issue_ctrl_pkg::*;
#(
   parameter int REGA_W = REGA_W_DEF,
   parameter int REGB_W = REGB_W_DEF
) (
   input  logic [REGA_W-1:0] sel_a,
   input  logic [REGB_W-1:0] sel_b,
   input  logic [REGA_W-1:0] dst,
   output logic              hit
);

   logic dst_nz;
   logic a_hit;
   logic b_hit;

   assign dst_nz = (dst != '0);
   assign a_hit  = (sel_a == dst);
   // selB only reaches the low registers; high dst bits must be zero
   assign b_hit  = (sel_b == dst[REGB_W-1:0]) &&
                   (dst[REGA_W-1:REGB_W] == '0);
   assign hit    = dst_nz && (a_hit || b_hit);

endmodule

// File: rtl/dec_issue_ctrl.sv
// Consumer-side control of the decode->execute latch: LAM
// sequencing, load-use bubbles and wrong-path squash after jumps.
module dec_issue_ctrl
   import dec_issue_ctrl_pkg::*;
#(
   parameter int REGA_W       = REGA_W_DEF,
   parameter int REGB_W       = REGB_W_DEF,
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REGA_W-1:0]     dec_selA,
   input  logic [REGB_W-1:0]     dec_selB,
   input  logic [REGA_W-1:0]     selOut_,
   input  logic                  lam_new_,
   input  logic [LAM_CTRL_W-1:0] lam_control_,
   input  logic                  new_jmp_,
   input  logic                  jmp_taken,
   input  logic                  mem_ack,
   output logic                  latch_en,
   output logic                  latch_flush,
   output logic                  mem_req,
   output logic [LAM_CTRL_W-1:0] mem_ctrl,
   output logic                  busy,
   output logic                  mem_err
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] TO_V = WC_W'(MEM_TIMEOUT);
   localparam logic [2:0]      FC_V = 3'(FLUSH_CYCLES);

   state_e            state;
   logic [WC_W-1:0]   wait_cnt;
   logic [2:0]        flush_cnt;
   logic [REGA_W-1:0] pend_dst;
   logic              pend_jmp;
   logic              hazard;
   logic              jmp_hit;

   assign jmp_hit = new_jmp_ & jmp_taken;

   hazard_cmp #(
      .REGA_W (REGA_W),
      .REGB_W (REGB_W)
   ) u_hazard (
      .sel_a (dec_selA),
      .sel_b (dec_selB),
      .dst   (pend_dst),
      .hit   (hazard)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_RUN;
         latch_en    <= 1'b1;
         latch_flush <= 1'b0;
         mem_req     <= 1'b0;
         mem_ctrl    <= '0;
         busy        <= 1'b0;
         mem_err     <= 1'b0;
         wait_cnt    <= '0;
         flush_cnt   <= '0;
         pend_dst    <= '0;
         pend_jmp    <= 1'b0;
      end else begin
         unique case (state)
            ST_RUN: begin
               latch_en    <= 1'b1;
               latch_flush <= 1'b0;
               if (lam_new_) begin
                  state    <= ST_MEM_WAIT;
                  mem_ctrl <= lam_control_;
                  pend_dst <= selOut_;
                  pend_jmp <= jmp_hit;
                  mem_req  <= 1'b1;
                  latch_en <= 1'b0;
                  busy     <= 1'b1;
                  wait_cnt <= WC_W'(1);
               end else if (jmp_hit) begin
                  state       <= ST_FLUSH;
                  flush_cnt   <= FC_V;
                  latch_flush <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               // an ack in the last allowed cycle still completes
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  latch_en <= 1'b1;
                  if (pend_jmp) begin
                     state       <= ST_FLUSH;
                     flush_cnt   <= FC_V;
                     latch_flush <= 1'b1;
                  end else if (hazard) begin
                     state       <= ST_LOAD_USE;
                     latch_flush <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                     busy  <= 1'b0;
                  end
               end else if (wait_cnt == TO_V) begin
                  state    <= ST_RUN;
                  mem_req  <= 1'b0;
                  mem_err  <= 1'b1;
                  latch_en <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_LOAD_USE: begin
               state       <= ST_RUN;
               latch_flush <= 1'b0;
               busy        <= 1'b0;
            end
            ST_FLUSH: begin
               if (flush_cnt == 3'd1) begin
                  state       <= ST_RUN;
                  latch_flush <= 1'b0;
                  busy        <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_dec_issue_ctrl.sv
// Bench for dec_issue_ctrl: directed scenarios plus random
// traffic against a cycle-count reference model.
module tb_dec_issue_ctrl;

   localparam int FC = 2;
   localparam int TO = 8;

   logic       clk;
   logic       reset;
   logic [5:0] dec_selA;
   logic [4:0] dec_selB;
   logic [5:0] selOut_;
   logic       lam_new_;
   logic [8:0] lam_control_;
   logic       new_jmp_;
   logic       jmp_taken;
   logic       mem_ack;

   logic       latch_en, latch_flush, mem_req, busy, mem_err;
   logic [8:0] mem_ctrl;
   logic       latch_en_t, latch_flush_t, mem_req_t, busy_t, mem_err_t;
   logic [8:0] mem_ctrl_t;

   int errors = 0;
   int checks = 0;

   bit       m_in_mem;
   int       m_age;
   int       m_bub;
   bit       m_err;
   bit [8:0] m_ctrl;
   int       m_dst;
   bit       m_pjmp;

   dec_issue_ctrl #(
      .FLUSH_CYCLES (FC),
      .MEM_TIMEOUT  (TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .dec_selA     (dec_selA),
      .dec_selB     (dec_selB),
      .selOut_      (selOut_),
      .lam_new_     (lam_new_),
      .lam_control_ (lam_control_),
      .new_jmp_     (new_jmp_),
      .jmp_taken    (jmp_taken),
      .mem_ack      (mem_ack),
      .latch_en     (latch_en),
      .latch_flush  (latch_flush),
      .mem_req      (mem_req),
      .mem_ctrl     (mem_ctrl),
      .busy         (busy),
      .mem_err      (mem_err)
   );

   dec_issue_ctrl #(
      .FLUSH_CYCLES (FC),
      .MEM_TIMEOUT  (4)
   ) dut_t (
      .clk          (clk),
      .reset        (reset),
      .dec_selA     (dec_selA),
      .dec_selB     (dec_selB),
      .selOut_      (selOut_),
      .lam_new_     (lam_new_),
      .lam_control_ (lam_control_),
      .new_jmp_     (new_jmp_),
      .jmp_taken    (jmp_taken),
      .mem_ack      (mem_ack),
      .latch_en     (latch_en_t),
      .latch_flush  (latch_flush_t),
      .mem_req      (mem_req_t),
      .mem_ctrl     (mem_ctrl_t),
      .busy         (busy_t),
      .mem_err      (mem_err_t)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // model: time spent in memory, bubbles still owed
   task automatic model_step();
      bit haz;
      if (reset) begin
         m_in_mem = 0; m_age = 0; m_bub = 0;
         m_err = 0; m_ctrl = 0; m_dst = 0; m_pjmp = 0;
      end else if (m_in_mem) begin
         m_age++;
         if (mem_ack) begin
            m_in_mem = 0;
            haz = (m_dst != 0) &&
                  ((int'(dec_selA) == m_dst) ||
                   (m_dst < 32 && int'(dec_selB) == m_dst));
            if (m_pjmp) m_bub = FC;
            else if (haz) m_bub = 1;
         end else if (m_age == TO) begin
            m_in_mem = 0;
            m_err = 1;
         end
      end else if (m_bub > 0) begin
         m_bub--;
      end else if (lam_new_) begin
         m_in_mem = 1;
         m_age = 0;
         m_ctrl = lam_control_;
         m_dst = int'(selOut_);
         m_pjmp = new_jmp_ && jmp_taken;
      end else if (new_jmp_ && jmp_taken) begin
         m_bub = FC;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_in();
      dec_selA = 0; dec_selB = 0; selOut_ = 0;
      lam_new_ = 0; lam_control_ = 0;
      new_jmp_ = 0; jmp_taken = 0; mem_ack = 0;
   endtask

   task automatic do_reset();
      idle_in();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      logic [13:0] got;
      do_reset();
      got = {latch_en, latch_flush, mem_req,
             busy, mem_err, mem_ctrl};
      checks++;
      if (got !== 14'b10000_000000000) begin
         errors++;
         $display("FAIL reset_state got=%b exp=%b",
                  got, 14'b10000_000000000);
      end
      tick();
      got = {latch_en, latch_flush, mem_req,
             busy, mem_err, mem_ctrl};
      checks++;
      if (got !== 14'b10000_000000000) begin
         errors++;
         $display("FAIL idle_state got=%b exp=%b",
                  got, 14'b10000_000000000);
      end
   endtask

   task automatic test_mem_ack();
      int lo = 0;
      do_reset();
      lam_new_ = 1;
      lam_control_ = 9'h1A5;
      tick();
      idle_in();
      checks++;
      if (mem_req !== 1'b1 || mem_ctrl !== 9'h1A5) begin
         errors++;
         $display("FAIL mem_start req=%b ctrl=%h exp=1/1a5",
                  mem_req, mem_ctrl);
      end
      for (int i = 0; i < 20; i++) begin
         if (!latch_en) lo++;
         mem_ack = !latch_en && lo == 5;
         tick();
      end
      mem_ack = 0;
      checks++;
      if (lo != 5) begin
         errors++;
         $display("FAIL mem_stall got=%0d exp=5", lo);
      end
      checks++;
      if ({mem_req, mem_err, busy, mem_ctrl} !== {3'b000, 9'h1A5}) begin
         errors++;
         $display("FAIL mem_done req=%b err=%b busy=%b ctrl=%h",
                  mem_req, mem_err, busy, mem_ctrl);
      end
   endtask

   task automatic test_load_use();
      logic [5:0] dst_t [4] = '{6'd7, 6'd0, 6'd39, 6'd39};
      logic [5:0] a_t   [4] = '{6'd0, 6'd0, 6'd0, 6'd39};
      logic [4:0] b_t   [4] = '{5'd7, 5'd0, 5'd7, 5'd0};
      int         exp_t [4] = '{1, 0, 0, 1};
      int fl;
      for (int k = 0; k < 4; k++) begin
         do_reset();
         lam_new_ = 1;
         selOut_ = dst_t[k];
         tick();
         idle_in();
         tick();
         tick();
         dec_selA = a_t[k];
         dec_selB = b_t[k];
         mem_ack = 1;
         tick();
         idle_in();
         fl = 0;
         for (int i = 0; i < 4; i++) begin
            if (latch_flush && latch_en) fl++;
            tick();
         end
         checks++;
         if (fl != exp_t[k]) begin
            errors++;
            $display("FAIL load_use case=%0d got=%0d exp=%0d",
                     k, fl, exp_t[k]);
         end
      end
   endtask

   task automatic test_jump();
      int fl;
      for (int t = 0; t < 2; t++) begin
         do_reset();
         fl = 0;
         for (int i = 0; i < 8; i++) begin
            new_jmp_ = (i < 3);
            jmp_taken = (i < 3) && t == 1;
            tick();
            if (latch_flush) fl++;
         end
         idle_in();
         checks++;
         if (fl != (t == 1 ? FC : 0)) begin
            errors++;
            $display("FAIL jump taken=%0d got=%0d exp=%0d",
                     t, fl, t == 1 ? FC : 0);
         end
      end
   endtask

   task automatic test_timeout();
      int hi = 0;
      do_reset();
      lam_new_ = 1;
      tick();
      idle_in();
      for (int i = 0; i < 12; i++) begin
         if (mem_req_t) hi++;
         tick();
      end
      checks++;
      if (hi != 4) begin
         errors++;
         $display("FAIL timeout_len got=%0d exp=4", hi);
      end
      checks++;
      if ({mem_err_t, busy_t, latch_en_t} !== 3'b101) begin
         errors++;
         $display("FAIL timeout_err got=%b exp=101",
                  {mem_err_t, busy_t, latch_en_t});
      end
      repeat (5) tick();
      checks++;
      if (mem_err_t !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky got=%b exp=1", mem_err_t);
      end
      do_reset();
      checks++;
      if (mem_err_t !== 1'b0) begin
         errors++;
         $display("FAIL err_clear got=%b exp=0", mem_err_t);
      end
      lam_new_ = 1;
      tick();
      idle_in();
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         if (mem_req_t) hi++;
         mem_ack = mem_req_t && hi == 4;
         tick();
      end
      mem_ack = 0;
      checks++;
      if (mem_err_t !== 1'b0 || hi != 4) begin
         errors++;
         $display("FAIL ack_at_limit err=%b len=%0d exp=0/4",
                  mem_err_t, hi);
      end
   endtask

   task automatic test_mem_jump();
      int lo = 0;
      int fl = 0;
      do_reset();
      lam_new_ = 1;
      new_jmp_ = 1;
      jmp_taken = 1;
      selOut_ = 6'd7;
      tick();
      idle_in();
      dec_selA = 6'd7;
      for (int i = 0; i < 12; i++) begin
         if (!latch_en) lo++;
         if (latch_flush) fl++;
         mem_ack = !latch_en && lo == 3;
         tick();
      end
      idle_in();
      checks++;
      if (lo != 3 || fl != FC) begin
         errors++;
         $display("FAIL mem_then_jump stall=%0d flush=%0d exp=3/%0d",
                  lo, fl, FC);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      lam_new_ = 1;
      tick();
      idle_in();
      tick();
      tick();
      checks++;
      if (mem_req !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre req=%b exp=1", mem_req);
      end
      reset = 1;
      tick();
      reset = 0;
      checks++;
      if ({mem_req, latch_en, busy, mem_err} !== 4'b0100) begin
         errors++;
         $display("FAIL mid_reset got=%b exp=0100",
                  {mem_req, latch_en, busy, mem_err});
      end
   endtask

   task automatic test_random();
      logic [13:0] got;
      logic [13:0] exp;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         reset = ($urandom % 100) == 0;
         lam_new_ = ($urandom % 4) == 0;
         lam_control_ = 9'($urandom);
         new_jmp_ = ($urandom % 3) == 0;
         jmp_taken = 1'($urandom);
         mem_ack = ($urandom % 4) == 0;
         if (($urandom % 5) == 0)
            selOut_ = 6'(32 + $urandom % 8);
         else
            selOut_ = 6'($urandom % 8);
         dec_selA = 6'($urandom % 8);
         dec_selB = 5'($urandom % 8);
         tick();
         got = {latch_en, latch_flush, mem_req,
                busy, mem_err, mem_ctrl};
         exp = {!m_in_mem, m_bub > 0, m_in_mem,
                m_in_mem || m_bub > 0, m_err, m_ctrl};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL random cyc=%0d got=%b exp=%b",
                     i, got, exp);
         end
      end
      reset = 0;
      idle_in();
   endtask

   initial begin
      reset = 1;
      idle_in();
      test_reset();
      test_mem_ack();
      test_load_use();
      test_jump();
      test_timeout();
      test_mem_jump();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
